// File: rtl/bus_seq.sv
// Read/write sequencer for the 8-bit multiplexed parallel bus, driving the bidir pad stage.
// One request per SETUP+STROBE+HOLD+3 cycles; req_ready is low for the whole transaction.
module bus_seq #(
  parameter int SETUP  = 1,
  parameter int STROBE = 2,
  parameter int HOLD   = 1
) (
  input  logic       clk,
  input  logic       aclr,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       oe,
  output logic [7:0] out,
  input  logic [7:0] in,
  output logic       ale,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n
);

  localparam logic [3:0] SETUP_M1  = 4'(SETUP - 1);
  localparam logic [3:0] STROBE_M1 = 4'(STROBE - 1);
  localparam logic [3:0] HOLD_M1   = 4'(HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LATCH, S_TURN, S_STRB, S_HOLD
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       we_q, we_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;

  logic       req_ready_q, req_ready_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic       oe_q, oe_d;
  logic [7:0] out_q, out_d;
  logic       ale_q, ale_d;
  logic       cs_n_q, cs_n_d;
  logic       rd_n_q, rd_n_d;
  logic       wr_n_q, wr_n_d;
  logic       data_phase;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d = S_ADDR;
          cnt_d   = SETUP_M1;
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
        end
      end
      S_ADDR: begin
        if (cnt_q == 4'd0) state_d = S_LATCH;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_LATCH: state_d = S_TURN;
      S_TURN: begin
        state_d = S_STRB;
        cnt_d   = STROBE_M1;
      end
      S_STRB: begin
        if (cnt_q == 4'd0) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_M1;
          // Pad value is sampled on the edge that ends the strobe, while rd_n is still low.
          if (!we_q) rsp_rdata_d = in;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d     = S_IDLE;
          rsp_valid_d = !we_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so every pin comes straight from a flop.
    data_phase  = (state_d == S_TURN) || (state_d == S_STRB) || (state_d == S_HOLD);
    req_ready_d = (state_d == S_IDLE);
    cs_n_d      = (state_d == S_IDLE);
    ale_d       = (state_d == S_ADDR);
    rd_n_d      = !((state_d == S_STRB) && !we_d);
    wr_n_d      = !((state_d == S_STRB) && we_d);
    if (state_d == S_IDLE) begin
      oe_d  = 1'b1;
      out_d = out_q;
    end else if (data_phase) begin
      oe_d  = !we_d;
      out_d = we_d ? wdata_d : addr_d;
    end else begin
      oe_d  = 1'b0;
      out_d = addr_d;
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      oe_q        <= 1'b1;
      out_q       <= 8'h00;
      ale_q       <= 1'b0;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      oe_q        <= oe_d;
      out_q       <= out_d;
      ale_q       <= ale_d;
      cs_n_q      <= cs_n_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign oe        = oe_q;
  assign out       = out_q;
  assign ale       = ale_q;
  assign cs_n      = cs_n_q;
  assign rd_n      = rd_n_q;
  assign wr_n      = wr_n_q;

endmodule

// File: tb/tb_bus_seq.sv
// Scoreboarded bench for bus_seq: default instance plus a SETUP=3/STROBE=4/HOLD=2 instance.
`timescale 1ns/1ps
module tb_bus_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       aclr;
  logic       req_valid, req_ready, req_we;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       oe, ale, cs_n, rd_n, wr_n;
  logic [7:0] out, pad_in, pad_val;

  logic       p_req_valid, p_req_ready, p_req_we;
  logic [7:0] p_req_addr, p_req_wdata;
  logic       p_rsp_valid;
  logic [7:0] p_rsp_rdata;
  logic       p_oe, p_ale, p_cs_n, p_rd_n, p_wr_n;
  logic [7:0] p_out;
  logic [7:0] p_in = 8'h00;

  // Pads only carry the read value while the strobe is low, so a mistimed capture shows up.
  assign pad_in = (rd_n == 1'b0) ? pad_val : 8'hEE;

  bus_seq u_dut (
    .clk(clk), .aclr(aclr), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .oe(oe), .out(out), .in(pad_in), .ale(ale), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n)
  );

  bus_seq #(.SETUP(3), .STROBE(4), .HOLD(2)) u_dut_p (
    .clk(clk), .aclr(aclr), .req_valid(p_req_valid), .req_ready(p_req_ready), .req_we(p_req_we),
    .req_addr(p_req_addr), .req_wdata(p_req_wdata), .rsp_valid(p_rsp_valid),
    .rsp_rdata(p_rsp_rdata), .oe(p_oe), .out(p_out), .in(p_in), .ale(p_ale), .cs_n(p_cs_n),
    .rd_n(p_rd_n), .wr_n(p_wr_n)
  );

  typedef struct { logic [7:0] d; int due; } rsp_t;
  logic [12:0] bus_q[$];
  rsp_t        rsp_q[$];

  int nvec = 0;
  int nfail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [12:0] bv(input logic a, input logic c, input logic r,
                                     input logic w, input logic o, input logic [7:0] d);
    return {a, c, r, w, o, d};
  endfunction

  // Expected bus cycles {ale,cs_n,rd_n,wr_n,oe,out} for the default timing.
  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    bus_q.push_back(bv(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, a));
    bus_q.push_back(bv(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, a));
    bus_q.push_back(bv(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, d));
    bus_q.push_back(bv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, d));
    bus_q.push_back(bv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, d));
    bus_q.push_back(bv(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, d));
  endtask

  task automatic push_rd(input logic [7:0] a, input int n);
    logic [12:0] t[6];
    t[0] = bv(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, a);
    t[1] = bv(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, a);
    t[2] = bv(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, a);
    t[3] = bv(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, a);
    t[4] = bv(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, a);
    t[5] = bv(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, a);
    for (int i = 0; i < n; i++) bus_q.push_back(t[i]);
  endtask

  // Presents a request and returns the cycle number of the accepting edge.
  task automatic issue(input logic we, input logic [7:0] a, input logic [7:0] d, output int acc);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    n = 0;
    while (req_ready !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 50) begin
        chk("accept_timeout", 32'd1, 32'd0);
        acc = cyc;
        return;
      end
    end
    @(posedge clk);
    #1;
    acc = cyc;
  endtask

  // Monitor: every bus cycle and every response is checked against the queued expectations.
  always @(negedge clk) begin
    if (aclr === 1'b0) begin
      if (cs_n === 1'b0) begin
        if (bus_q.size() == 0) chk("bus_unexpected", 32'd1, 32'd0);
        else chk("bus", 32'({ale, cs_n, rd_n, wr_n, oe, out}), 32'(bus_q.pop_front()));
      end
      if (rsp_valid !== 1'b0) begin
        if (rsp_q.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          rsp_t r;
          r = rsp_q.pop_front();
          chk("rsp_rdata", 32'(rsp_rdata), 32'(r.d));
          chk("rsp_cycle", cyc, r.due);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, a1, a2, n, n_busy, n_ale, n_wr, n_oe, n_rsp;
    aclr = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'hFF; req_wdata = 8'hFF;
    pad_val = 8'h00;
    p_req_valid = 1'b0; p_req_we = 1'b0; p_req_addr = 8'h00; p_req_wdata = 8'h00;

    // Reset held with a pending request: everything stays at reset values.
    repeat (3) begin
      @(negedge clk);
      chk("reset_outs", 32'({req_ready, rsp_valid, rsp_rdata, oe, out, ale, cs_n, rd_n, wr_n}),
          32'({1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1}));
    end
    req_valid = 1'b0;
    aclr = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", 32'({req_ready, cs_n}), 32'(2'b11));

    // Single write 0x24 <- 0x5A.
    push_wr(8'h24, 8'h5A);
    issue(1'b1, 8'h24, 8'h5A, a);
    req_valid = 1'b0;
    @(negedge clk);
    chk("ready_drop", 32'(req_ready), 32'd0);
    repeat (8) @(negedge clk);

    // Single read 0x81, pads return 0xC3.
    pad_val = 8'hC3;
    push_rd(8'h81, 6);
    issue(1'b0, 8'h81, 8'h00, a);
    req_valid = 1'b0;
    rsp_q.push_back('{8'hC3, a + 6});
    repeat (10) @(negedge clk);
    chk("rdata_persist", 32'(rsp_rdata), 32'h0000_00C3);

    // Back-to-back write then read with req_valid held high.
    pad_val = 8'h3C;
    push_wr(8'h10, 8'hA5);
    push_rd(8'h42, 6);
    issue(1'b1, 8'h10, 8'hA5, a1);
    req_we = 1'b0; req_addr = 8'h42; req_wdata = 8'h00;
    issue(1'b0, 8'h42, 8'h00, a2);
    req_valid = 1'b0;
    rsp_q.push_back('{8'h3C, a2 + 6});
    chk("b2b_gap", a2 - a1, 32'd7);
    chk("rdata_kept_over_write", 32'(rsp_rdata), 32'h0000_00C3);
    @(negedge clk);
    chk("b2b_ready_low", 32'(req_ready), 32'd0);
    repeat (10) @(negedge clk);

    // Reset during the read strobe aborts with no response.
    pad_val = 8'h77;
    push_rd(8'h66, 4);
    issue(1'b0, 8'h66, 8'h00, a);
    req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rd_n !== 1'b0 && n < 20);
    chk("abort_saw_strobe", 32'(rd_n), 32'd0);
    #2 aclr = 1'b1;
    #1;
    chk("abort_pins", 32'({rd_n, cs_n, oe}), 32'(3'b111));
    chk("abort_rdata", 32'(rsp_rdata), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    aclr = 1'b0;
    repeat (8) @(negedge clk);
    chk("bus_q_drained", bus_q.size(), 32'd0);
    chk("rsp_q_drained", rsp_q.size(), 32'd0);

    // Stretched timing instance: single write.
    @(negedge clk);
    p_req_valid = 1'b1; p_req_we = 1'b1; p_req_addr = 8'h3A; p_req_wdata = 8'h99;
    @(posedge clk);
    #1 p_req_valid = 1'b0;
    n_busy = 0; n_ale = 0; n_wr = 0; n_oe = 0; n_rsp = 0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (p_rsp_valid) n_rsp++;
      if (p_req_ready) break;
      n_busy++;
      if (p_ale) n_ale++;
      if (!p_wr_n) n_wr++;
      if (p_oe) n_oe++;
    end
    chk("p_busy_cycles", n_busy, 32'd11);
    chk("p_ale_cycles", n_ale, 32'd3);
    chk("p_wr_cycles", n_wr, 32'd4);
    chk("p_oe_high_in_write", n_oe, 32'd0);
    chk("p_no_rsp", n_rsp, 32'd0);
    chk("p_rd_idle", 32'(p_rd_n), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/bus_seq.md
# bus_seq

Transaction sequencer for the 8-bit multiplexed parallel bus, directly upstream of the `bidir` pad stage. It accepts single read/write requests through a valid/ready handshake and generates the address phase, ALE, turnaround and RD/WR strobes with parameterised cycle counts. It drives `oe`/`out` into `bidir` and samples `in` from it, returning read data on a one-cycle response pulse.

## Interface
- `SETUP`, default 1: address phase cycles; legal range 1..15.
- `STROBE`, default 2: RD/WR strobe-low cycles; legal range 1..15.
- `HOLD`, default 1: post-strobe hold cycles; legal range 1..15.
- `clk`  in  1  system clock, rising edge; target period 500 ns.
- `aclr`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer idle and able to accept a request.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  8  bus address.
- `req_wdata`  in  8  write data.
- `rsp_valid`  out  1  one-cycle pulse when read data is valid.
- `rsp_rdata`  out  8  read data; holds its value until the next read completes.
- `oe`  out  1  to `bidir`; 1 = pads released to Z, 0 = `out` driven.
- `out`  out  8  to `bidir`; value driven onto the pads.
- `in`  in  8  from `bidir`; pad value.
- `ale`  out  1  address latch enable, active-high.
- `cs_n`, `rd_n`, `wr_n`  out  1 each  chip select, read strobe and write strobe, active-low.

## Operation
- All outputs are registered. Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0x00, `oe`=1, `out`=0x00, `ale`=0, `cs_n`=1, `rd_n`=1, `wr_n`=1.
- Handshake: a request is accepted on a rising edge where `req_valid`&&`req_ready`. The sequencer latches `req_we`, `req_addr` and `req_wdata` at that edge. `req_ready` goes 0 on the following cycle.
- FSM states:
  - IDLE: `req_ready`=1, `cs_n`=1, `oe`=1. On acceptance, go to ADDR.
  - ADDR, `SETUP` cycles: `cs_n`=0, `oe`=0, `out`=addr, `ale`=1.
  - LATCH, 1 cycle: `ale`=0; addr is still driven.
  - TURN, 1 cycle. Write: `out`=wdata, `oe`=0. Read: `oe`=1; `out` holds addr, which is don't-care.
  - STRB, `STROBE` cycles: `wr_n`=0 (write) or `rd_n`=0 (read). Write data and `oe` are unchanged from TURN.
  - HOLD, `HOLD` cycles: strobes return to 1; `cs_n`=0; `oe` and `out` are unchanged. Then go to IDLE.
- Read capture: `in` is sampled into `rsp_rdata` at the rising edge ending the last STRB cycle, while `rd_n` is still 0.
- Read response: `rsp_valid`=1 for exactly the first IDLE cycle after a read. Writes never assert `rsp_valid`.
- Phase counter: 4 bits, reloaded with N-1 on entry to each multi-cycle state and decremented each cycle. The state exits when the counter reaches 0.
- Write transactions never set `oe`=1 between ADDR and HOLD. Read transactions never drive `oe`=0 after LATCH.
- Reset mid-transaction: `aclr` forces all outputs to their reset values asynchronously. No `rsp_valid` is produced for the aborted transaction, and the latched request is discarded.
- `req_valid` asserted while `req_ready`=0 is ignored. The requester must hold the request until it is accepted.

## Timing
- Transaction length from the acceptance edge to the return to IDLE is `SETUP`+`STROBE`+`HOLD`+2 cycles; the default is 6.
- There is a minimum of one IDLE cycle (`req_ready`=1) between back-to-back transactions. Throughput is therefore one transaction per `SETUP`+`STROBE`+`HOLD`+3 cycles; the default is 7.
- Read latency from the acceptance edge to `rsp_valid` is `SETUP`+`STROBE`+`HOLD`+2 cycles.
- Address setup to ALE falling edge is ≥ `SETUP` cycles. Address hold after ALE falls is 1 cycle.
- Bus turnaround: for reads, 1 cycle with pads released before `rd_n` falls. Data is stable for the whole strobe plus `HOLD`.

## Test plan
- Reset: assert `aclr` for 3 cycles with `req_valid`=1 -> all outputs at their reset values. No transaction starts until `aclr` is deasserted.
- Single write, addr 0x24, data 0x5A, defaults:
  - `out`=0x24 with `ale`=1 for 1 cycle, then 0x24 with `ale`=0 for 1 cycle.
  - `out`=0x5A with `wr_n`=1 for 1 cycle, then `wr_n`=0 for 2 cycles, then 1 hold cycle.
  - `oe`=0 for all 6 cycles, `cs_n`=0 for all 6 cycles, `rd_n`=1 throughout, `rsp_valid` never asserted.
- Single read, addr 0x81, `in`=0xC3 during STRB, defaults:
  - `oe`=1 from TURN onward and `rd_n`=0 for 2 cycles.
  - `rsp_valid` pulses once, 6 cycles after acceptance, with `rsp_rdata`=0xC3, which persists afterwards.
- Back-to-back: `req_valid` held 1 for a write then a read -> exactly one `req_ready`=1 cycle between them; the second transaction starts with ADDR on the next cycle.
- Reset mid-STRB of a read: `aclr` asserted while `rd_n`=0 -> `rd_n`, `cs_n` and `oe` go to 1 immediately. No `rsp_valid`; `rsp_rdata` reads 0x00.
- Parameters `SETUP`=3, `STROBE`=4, `HOLD`=2, single write -> `ale`=1 for 3 cycles, `wr_n`=0 for 4 cycles, transaction lasts 11 cycles before `req_ready` returns to 1.
